reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 No parameters; widths fixed at 16 registers x 16 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instruction present on opcode/rd/rs1/rs2/imm.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 opcode  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 NOP.
REQ-007 rd, rs1, rs2  input  4 each  destination and source register indices.
REQ-008 imm  input  8  immediate for LDI.
REQ-009 rf_we  output  1  register-file write enable.
REQ-010 rf_addr_write, rf_addr_read1, rf_addr_read2  output  4 each  register-file addresses.
REQ-011 rf_data_in  output  16  register-file write data.
REQ-012 rf_data_out1, rf_data_out2  input  16 each  register-file read data, registered, valid one edge after address.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.
REQ-014 result  output  16  last computed result, held until next EXEC.
REQ-015 zero, carry  output  1 each  flags of last result.

Function
REQ-016 FSM states IDLE, READ, EXEC, WRITE; sequence IDLE->READ->EXEC->WRITE->IDLE, no skips.
REQ-017 instr_ready = 1 only in IDLE; handshake instr_valid&&instr_ready latches opcode/rd/rs1/rs2/imm and moves to READ.
REQ-018 instr_valid in non-IDLE states ignored; inputs may change freely while instr_ready = 0.
REQ-019 rf_addr_read1/rf_addr_read2 driven from latched rs1/rs2 in all non-IDLE states; regfile data sampled in EXEC.
REQ-020 EXEC registers result: ADD/SUB modulo 2^16, carry = bit 16 of ADD or borrow of SUB (rs1 < rs2); logic ops bitwise; MOV = rs1 value; LDI = {8'h00, imm}; carry = 0 for non-ADD/SUB.
REQ-021 zero = (result == 0), updated with result; NOP leaves result, zero, carry unchanged.
REQ-022 WRITE: rf_we = 1, rf_addr_write = latched rd, rf_data_in = result; NOP drives rf_we = 0; done = 1 for every opcode.
REQ-023 rf_we = 0 in all states other than WRITE; single write per instruction.
REQ-024 Throughput one instruction per 4 cycles; accept edge to done pulse = 3 cycles.
REQ-025 Back-to-back dependency (rd of instr N = rs of instr N+1) returns the new value; write commits before next READ.
REQ-026 rd = rs1 = rs2 legal; sources read before write.

Reset
REQ-027 reset_n low: state IDLE, instr_ready = 1, rf_we = 0, done = 0, result = 0, zero = 1, carry = 0, latched fields = 0, all addresses 0.
REQ-028 Reset asserted mid-instruction aborts it: no write, no done pulse, IDLE on release.

Configuration
REQ-029 Macro REG_ACCESS_ZERO_REG_EN defined: register 0 hard-wired; reads of index 0 use 16'h0000 in EXEC regardless of rf_data_out, writes with rd = 0 drive rf_we = 0 (done still pulses, result/flags still update).
REQ-030 Macro undefined: register 0 is a normal register, no special casing.

Verification
REQ-031 Reset, then LDI r1,0x34; LDI r2,0x12; ADD r3,r1,r2 -> r3 = 0x0046, zero = 0, carry = 0, done 3 cycles after each accept.
REQ-032 r1 = 0x0000 via LDI; SUB r4,r1,r2 with r2 = 0x0012 -> r4 = 0xFFEE, carry = 1; ADD of 0xFFFF+0x0001 (via LDI/SUB setup) -> 0x0000, zero = 1, carry = 1.
REQ-033 instr_valid held high continuously with changing fields -> only fields present on IDLE-cycle accepts are executed; instr_ready pattern 1,0,0,0 repeating.
REQ-034 Assert reset_n low during EXEC of ADD r5 -> no rf_we pulse, r5 unchanged, outputs at REQ-027 values.
REQ-035 NOP -> done pulse, rf_we stays 0, result/flags unchanged.
REQ-036 With REG_ACCESS_ZERO_REG_EN: LDI r0,0xFF then MOV r6,r0 -> no write to r0, r6 = 0x0000; without macro r6 = 0x00FF.

Source files
------------

// File: rtl/reg_access_ctrl_if.sv
// Bus interface for reg_access_ctrl: instruction handshake, register-file
// port and result/flag outputs. The "slave" modport is the controller view;
// the "master" modport is the instruction source / register-file side.
interface reg_access_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [7:0]  imm;
  logic        rf_we;
  logic [3:0]  rf_addr_write;
  logic [3:0]  rf_addr_read1;
  logic [3:0]  rf_addr_read2;
  logic [15:0] rf_data_in;
  logic [15:0] rf_data_out1;
  logic [15:0] rf_data_out2;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic        carry;

  modport slave (
    input  instr_valid, opcode, rd, rs1, rs2, imm, rf_data_out1, rf_data_out2,
    output instr_ready, rf_we, rf_addr_write, rf_addr_read1, rf_addr_read2,
           rf_data_in, done, result, zero, carry
  );

  modport master (
    output instr_valid, opcode, rd, rs1, rs2, imm, rf_data_out1, rf_data_out2,
    input  instr_ready, rf_we, rf_addr_write, rf_addr_read1, rf_addr_read2,
           rf_data_in, done, result, zero, carry
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: four-state (IDLE/READ/EXEC/WRITE) controller that fetches
// two operands from an external 16x16 register file with one-edge registered
// read latency, computes a 16-bit ALU result with zero/carry flags, and writes
// it back. One instruction every four cycles.
// Optional feature macro REG_ACCESS_ZERO_REG_EN: register 0 reads as zero and
// writes to it are suppressed (done, result and flags still behave normally).
module reg_access_ctrl (
  input  logic               clk,
  input  logic               reset_n,
  reg_access_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        accept_s;

  logic [2:0]  opcode_r;
  logic [3:0]  rd_r;
  logic [3:0]  rs1_r;
  logic [3:0]  rs2_r;
  logic [7:0]  imm_r;

  logic [15:0] op_a_s;
  logic [15:0] op_b_s;
  logic [16:0] alu_s;
  logic        carry_nxt_s;
  logic        upd_s;
  logic        wr_en_s;

  logic        instr_ready_r;
  logic        rf_we_r;
  logic        done_r;
  logic [15:0] result_r;
  logic        zero_r;
  logic        carry_r;

  // Ready is only ever high in IDLE, so this is the IDLE handshake.
  assign accept_s = bus.instr_valid && instr_ready_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fixed IDLE->READ->EXEC->WRITE->IDLE walk.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ:  state_nxt_s = ST_EXEC;
      ST_EXEC:  state_nxt_s = ST_WRITE;
      ST_WRITE: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Capture instruction fields on the handshake; inputs are free afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_r <= 3'b000;
      rd_r     <= 4'h0;
      rs1_r    <= 4'h0;
      rs2_r    <= 4'h0;
      imm_r    <= 8'h00;
    end else if (accept_s) begin
      opcode_r <= bus.opcode;
      rd_r     <= bus.rd;
      rs1_r    <= bus.rs1;
      rs2_r    <= bus.rs2;
      imm_r    <= bus.imm;
    end
  end

  // Operand selection from register-file read data (register 0 may read as zero).
  always_comb begin
    op_a_s = bus.rf_data_out1;
    op_b_s = bus.rf_data_out2;
`ifdef REG_ACCESS_ZERO_REG_EN
    if (rs1_r == 4'h0) begin
      op_a_s = 16'h0000;
    end else begin
      op_a_s = bus.rf_data_out1;
    end
    if (rs2_r == 4'h0) begin
      op_b_s = 16'h0000;
    end else begin
      op_b_s = bus.rf_data_out2;
    end
`endif
  end

  // ALU: bit 16 of ADD is the carry, bit 16 of SUB is the borrow (a < b).
  always_comb begin
    alu_s       = 17'h00000;
    carry_nxt_s = 1'b0;
    upd_s       = 1'b1;
    case (opcode_r)
      OP_ADD: begin
        alu_s       = {1'b0, op_a_s} + {1'b0, op_b_s};
        carry_nxt_s = alu_s[16];
      end
      OP_SUB: begin
        alu_s       = {1'b0, op_a_s} - {1'b0, op_b_s};
        carry_nxt_s = alu_s[16];
      end
      OP_AND:  alu_s = {1'b0, op_a_s & op_b_s};
      OP_OR:   alu_s = {1'b0, op_a_s | op_b_s};
      OP_XOR:  alu_s = {1'b0, op_a_s ^ op_b_s};
      OP_MOV:  alu_s = {1'b0, op_a_s};
      OP_LDI:  alu_s = {9'h000, imm_r};
      OP_NOP:  upd_s = 1'b0;
      default: upd_s = 1'b0;
    endcase
  end

  // Write-back is suppressed for NOP (and for register 0 when it is hard-wired).
  always_comb begin
    wr_en_s = (opcode_r != OP_NOP);
`ifdef REG_ACCESS_ZERO_REG_EN
    if (rd_r == 4'h0) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = (opcode_r != OP_NOP);
    end
`endif
  end

  // Handshake/strobe outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_ready_r <= 1'b1;
      rf_we_r       <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      instr_ready_r <= (state_nxt_s == ST_IDLE);
      done_r        <= (state_nxt_s == ST_WRITE);
      rf_we_r       <= (state_nxt_s == ST_WRITE) && wr_en_s;
    end
  end

  // Result and flags are registered at the end of EXEC and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_r <= 16'h0000;
      zero_r   <= 1'b1;
      carry_r  <= 1'b0;
    end else if ((state_r == ST_EXEC) && upd_s) begin
      result_r <= alu_s[15:0];
      zero_r   <= (alu_s[15:0] == 16'h0000);
      carry_r  <= carry_nxt_s;
    end
  end

  assign bus.instr_ready   = instr_ready_r;
  assign bus.rf_we         = rf_we_r;
  assign bus.rf_addr_write = rd_r;
  assign bus.rf_addr_read1 = rs1_r;
  assign bus.rf_addr_read2 = rs2_r;
  assign bus.rf_data_in    = result_r;
  assign bus.done          = done_r;
  assign bus.result        = result_r;
  assign bus.zero          = zero_r;
  assign bus.carry         = carry_r;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl: the driver pushes hand-computed
// expectations at each accept; a negedge monitor pops and compares at done.
module tb_reg_access_ctrl;

  logic clk;
  logic reset_n;
  logic mem_clr;
  int   cyc;
  int   checks;
  int   errors;
  int   next_id;

  typedef struct {
    int          id;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] res;
    logic        z;
    logic        c;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] rf [16];

  reg_access_ctrl_if bus();

  reg_access_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, MOV = 3'b101, LDI = 3'b110, NOP = 3'b111;

  // Fields presented on consecutive cycles with instr_valid held high.
  localparam logic [22:0] FLOOD [12] = '{
    {LDI, 4'd5, 4'd0, 4'd0, 8'h11}, {LDI, 4'd5, 4'd0, 4'd0, 8'hAA},
    {ADD, 4'd5, 4'd1, 4'd1, 8'h00}, {LDI, 4'd6, 4'd0, 4'd0, 8'hBB},
    {LDI, 4'd6, 4'd0, 4'd0, 8'h22}, {SUB, 4'd7, 4'd4, 4'd3, 8'h00},
    {LDI, 4'd7, 4'd0, 4'd0, 8'hCC}, {MOV, 4'd7, 4'd4, 4'd0, 8'h00},
    {ADD, 4'd7, 4'd5, 4'd6, 8'h00}, {LDI, 4'd7, 4'd0, 4'd0, 8'hDD},
    {NOP, 4'd7, 4'd0, 4'd0, 8'h00}, {XOR_, 4'd7, 4'd7, 4'd7, 8'h00}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model with registered reads (reads see the pre-write value).
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 16; k++) rf[k] <= 16'h0000;
    end else if (bus.rf_we) begin
      rf[bus.rf_addr_write] <= bus.rf_data_in;
    end
    bus.rf_data_out1 <= rf[bus.rf_addr_read1];
    bus.rf_data_out2 <= rf[bus.rf_addr_read2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [3:0] wa, input logic [15:0] res,
                      input logic z, input logic c, input int acc);
    exp_t e;
    e.id = next_id; e.we = we; e.wa = wa; e.res = res; e.z = z; e.c = c; e.acc = acc;
    next_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.rf_we && !bus.done) chk("stray_rf_we", 32'(bus.rf_we), 32'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("i%0d_rf_we", e.id), 32'(bus.rf_we), 32'(e.we));
          if (e.we) begin
            chk($sformatf("i%0d_waddr", e.id), 32'(bus.rf_addr_write), 32'(e.wa));
            chk($sformatf("i%0d_wdata", e.id), 32'(bus.rf_data_in), 32'(e.res));
          end
          chk($sformatf("i%0d_result", e.id), 32'(bus.result), 32'(e.res));
          chk($sformatf("i%0d_zero", e.id), 32'(bus.zero), 32'(e.z));
          chk($sformatf("i%0d_carry", e.id), 32'(bus.carry), 32'(e.c));
          chk($sformatf("i%0d_latency", e.id), 32'(cyc - e.acc), 32'd2);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [7:0] im, input logic we,
                       input logic [15:0] res, input logic z, input logic c);
    wait_ready();
    bus.opcode = op; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    push(we, d, res, z, c, cyc);
    bus.instr_valid = 1'b0;
    bus.opcode = 3'b000; bus.rd = 4'hF; bus.rs1 = 4'hF; bus.rs2 = 4'hF; bus.imm = 8'h5A;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'h0000);
    chk({tag, "_zero"}, 32'(bus.zero), 32'd1);
    chk({tag, "_carry"}, 32'(bus.carry), 32'd0);
    chk({tag, "_addrs"}, 32'({bus.rf_addr_write, bus.rf_addr_read1, bus.rf_addr_read2}), 32'h000);
  endtask

  initial begin
    int n;
    cyc = 0; checks = 0; errors = 0; next_id = 0;
    mem_clr = 1'b1;
    reset_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode = 3'b000; bus.rd = 4'h0; bus.rs1 = 4'h0; bus.rs2 = 4'h0; bus.imm = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset_n = 1'b1;
    mem_clr = 1'b0;

    // Loads, add, subtract with borrow, add wrapping to zero.
    issue(LDI, 4'd1, 4'd0, 4'd0, 8'h34, 1'b1, 16'h0034, 1'b0, 1'b0);
    issue(LDI, 4'd2, 4'd0, 4'd0, 8'h12, 1'b1, 16'h0012, 1'b0, 1'b0);
    issue(ADD, 4'd3, 4'd1, 4'd2, 8'h00, 1'b1, 16'h0046, 1'b0, 1'b0);
    issue(LDI, 4'd1, 4'd0, 4'd0, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue(SUB, 4'd4, 4'd1, 4'd2, 8'h00, 1'b1, 16'hFFEE, 1'b0, 1'b1);
    issue(LDI, 4'd8, 4'd0, 4'd0, 8'h01, 1'b1, 16'h0001, 1'b0, 1'b0);
    issue(SUB, 4'd9, 4'd1, 4'd8, 8'h00, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    issue(ADD, 4'd10, 4'd9, 4'd8, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b1);
    // NOP keeps result 0, zero 1, carry 1 and never writes.
    issue(NOP, 4'd5, 4'd3, 4'd4, 8'h77, 1'b0, 16'h0000, 1'b1, 1'b1);
    // Logic ops and MOV clear carry.
    issue(AND_, 4'd11, 4'd3, 4'd4, 8'h00, 1'b1, 16'h0046, 1'b0, 1'b0);
    issue(OR_, 4'd12, 4'd3, 4'd2, 8'h00, 1'b1, 16'h0056, 1'b0, 1'b0);
    issue(XOR_, 4'd13, 4'd3, 4'd2, 8'h00, 1'b1, 16'h0054, 1'b0, 1'b0);
    issue(MOV, 4'd14, 4'd4, 4'd0, 8'h00, 1'b1, 16'hFFEE, 1'b0, 1'b0);
    // rd = rs1 = rs2, then back-to-back dependency on the new r2.
    issue(ADD, 4'd2, 4'd2, 4'd2, 8'h00, 1'b1, 16'h0024, 1'b0, 1'b0);
    issue(ADD, 4'd15, 4'd2, 4'd3, 8'h00, 1'b1, 16'h006A, 1'b0, 1'b0);

    // instr_valid held high with fields changing every cycle.
    wait_ready();
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("flood_ready_%0d", i), 32'(bus.instr_ready), 32'((i % 4) == 0));
      {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm} = FLOOD[i];
      if (i == 0) push(1'b1, 4'd5, 16'h0011, 1'b0, 1'b0, cyc + 1);
      if (i == 4) push(1'b1, 4'd6, 16'h0022, 1'b0, 1'b0, cyc + 1);
      if (i == 8) push(1'b1, 4'd7, 16'h0033, 1'b0, 1'b0, cyc + 1);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;

    // Reset asserted while ADD r5 is in EXEC: aborted, no write.
    wait_ready();
    bus.opcode = ADD; bus.rd = 4'd5; bus.rs1 = 4'd5; bus.rs2 = 4'd6; bus.imm = 8'h00;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset_state("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("post_abort");
    chk("abort_r5_kept", 32'(rf[5]), 32'h0011);

    // Register 0 behaviour.
`ifdef REG_ACCESS_ZERO_REG_EN
    issue(LDI, 4'd0, 4'd0, 4'd0, 8'hFF, 1'b0, 16'h00FF, 1'b0, 1'b0);
    issue(MOV, 4'd6, 4'd0, 4'd0, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b0);
`else
    issue(LDI, 4'd0, 4'd0, 4'd0, 8'hFF, 1'b1, 16'h00FF, 1'b0, 1'b0);
    issue(MOV, 4'd6, 4'd0, 4'd0, 8'h00, 1'b1, 16'h00FF, 1'b0, 1'b0);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rf3", 32'(rf[3]), 32'h0046);
    chk("rf4", 32'(rf[4]), 32'hFFEE);
    chk("rf7", 32'(rf[7]), 32'h0033);
    chk("rf15", 32'(rf[15]), 32'h006A);
`ifdef REG_ACCESS_ZERO_REG_EN
    chk("rf0", 32'(rf[0]), 32'h0000);
    chk("rf6", 32'(rf[6]), 32'h0000);
`else
    chk("rf0", 32'(rf[0]), 32'h00FF);
    chk("rf6", 32'(rf[6]), 32'h00FF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
